le_response_checker: RTL and testbench
======================================

Name: le_response_checker

Overview:
Synthesizable response checker for 4-bit less-or-equal comparator cells, sitting on the DUT output side of a comparator.
- Each valid cycle it samples the operand pair (a, b) and the cell's 1-bit result, and computes the golden a <= b (unsigned).
- It counts samples and mismatches, captures the first failing vector, and reports pass/fail at end of run.
- Intended for regression benches and on-chip self-test wrappers around comparator cells.

Parameters:
WIDTH, 4, operand width in bits (unsigned compare)
CNT_WIDTH, 8, width of sample and error counters
NUM_VECTORS, 5, samples per run before automatic completion; must be 1 .. 2^CNT_WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin run: one-cycle pulse, honoured in IDLE or DONE only
stop  input  1  abort run early, honoured in RUN only
valid  input  1  a, b, dut_out are valid this cycle
a  input  WIDTH  operand A as applied to the DUT
b  input  WIDTH  operand B as applied to the DUT
dut_out  input  1  DUT result for (a, b)
busy  output  1  high in RUN
done  output  1  high in DONE, held until next start
pass  output  1  valid while done; 1 iff zero mismatches and at least one sample
mismatch  output  1  one-cycle registered pulse per mismatching sample
sample_cnt  output  CNT_WIDTH  samples checked this run
err_cnt  output  CNT_WIDTH  mismatches this run, saturates at all-ones
fail_a  output  WIDTH  a of first mismatch
fail_b  output  WIDTH  b of first mismatch
fail_out  output  1  dut_out of first mismatch
fail_valid  output  1  fail_* hold a captured vector

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk edge. Clock is clk, reset is rst_n.
  - Reset forces state IDLE and drives every output to 0.
  - Reset has priority over all inputs, including mid-run.
  - After reset, no partial results are retained.
- State machine: IDLE -> RUN -> DONE -> RUN ...
  - IDLE:
    - start: go to RUN; clear sample_cnt, err_cnt, fail_*, fail_valid, pass.
    - valid is ignored.
  - RUN (busy=1):
    - Per valid cycle: expected = (a <= b), unsigned, WIDTH bits.
    - sample_cnt increments on the next edge.
    - If dut_out != expected:
      - err_cnt increments, saturating at 2^CNT_WIDTH-1.
      - mismatch pulses high for exactly the next cycle.
      - If fail_valid=0, capture a, b, dut_out into fail_* and set fail_valid. Later mismatches never overwrite the capture.
    - Transition to DONE on the edge where sample_cnt reaches NUM_VECTORS, or on stop.
    - start while in RUN is ignored.
  - DONE (done=1):
    - pass = (err_cnt==0) && (sample_cnt!=0). It is registered on entry to DONE.
    - Counters and fail_* hold their values.
    - valid is ignored.
    - start restarts the run: clear everything, enter RUN, drop done.
- Latency:
  - All outputs are registered and reflect a sample one cycle after the valid edge.
  - done rises in the same cycle that sample_cnt shows NUM_VECTORS.
- Simultaneous events:
  - valid+stop in RUN: the sample is checked and counted, then DONE.
  - valid on the start cycle: not counted. Checking begins the cycle after entering RUN.
  - stop outside RUN: ignored.
  - start+stop together in DONE: start wins.
- Boundaries:
  - stop before any sample gives done=1, pass=0, sample_cnt=0.
  - a==b must expect 1.
  - a=2^WIDTH-1, b=0 must expect 0.

Test Plan:
- Reset, start, then a correct DUT model for vectors (0,0), (2,0), (3,1), (4,6), (3,2) -> done after 5th sample; sample_cnt=5, err_cnt=0, pass=1, fail_valid=0.
- Same vectors with dut_out forced to 1 -> mismatches on (2,0), (3,1), (3,2); err_cnt=3, pass=0; fail_a=2, fail_b=0, fail_out=1; mismatch pulses exactly 3 times.
- start, two valid samples, stop asserted together with a third valid -> sample_cnt=3, done=1 next cycle; further valid cycles do not change counters.
- Assert rst_n=0 mid-run after two mismatches -> all outputs 0 next cycle, state IDLE; valid is then ignored until start.
- CNT_WIDTH=2, NUM_VECTORS=3, inject four mismatching samples via stop-free run -> run ends at 3 with err_cnt=3. Separately, with NUM_VECTORS=3 and err_cnt at 3, confirm no wrap.
- Back-to-back runs: in DONE, pulse start with valid high -> counters cleared, the start-cycle sample is not counted, and the second run's results are independent of the first.

Source files
------------

// File: rtl/le_response_checker.sv
// Response checker for unsigned less-or-equal comparator cells: checks each sampled
// (a, b, dut_out) against a <= b, counts samples and errors, and keeps the first failing vector.
module le_response_checker #(
   parameter int WIDTH       = 4,
   parameter int CNT_WIDTH   = 8,
   parameter int NUM_VECTORS = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 valid,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 dut_out,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic                 mismatch,
   output logic [CNT_WIDTH-1:0] sample_cnt,
   output logic [CNT_WIDTH-1:0] err_cnt,
   output logic [WIDTH-1:0]     fail_a,
   output logic [WIDTH-1:0]     fail_b,
   output logic                 fail_out,
   output logic                 fail_valid
);

   // Handshake: a sample is taken on every rising edge where valid=1 while busy=1;
   // there is no back-pressure, the checker accepts one sample per cycle.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(NUM_VECTORS);

   // state is kept as a named register so checkers can bind to it directly
   state_t                 state;
   state_t                 state_nx;
   logic [CNT_WIDTH-1:0]   sample_cnt_nx;
   logic [CNT_WIDTH-1:0]   err_cnt_nx;
   logic                   pass_nx;
   logic                   mismatch_nx;
   logic [WIDTH-1:0]       fail_a_nx;
   logic [WIDTH-1:0]       fail_b_nx;
   logic                   fail_out_nx;
   logic                   fail_valid_nx;
   logic                   expected;
   logic                   sample_hit;
   logic                   miss;

   assign expected   = (a <= b);
   assign sample_hit = (state == S_RUN) && valid;
   assign miss       = sample_hit && (dut_out != expected);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         sample_cnt <= '0;
         err_cnt    <= '0;
         pass       <= 1'b0;
         mismatch   <= 1'b0;
         fail_a     <= '0;
         fail_b     <= '0;
         fail_out   <= 1'b0;
         fail_valid <= 1'b0;
      end else begin
         state      <= state_nx;
         sample_cnt <= sample_cnt_nx;
         err_cnt    <= err_cnt_nx;
         pass       <= pass_nx;
         mismatch   <= mismatch_nx;
         fail_a     <= fail_a_nx;
         fail_b     <= fail_b_nx;
         fail_out   <= fail_out_nx;
         fail_valid <= fail_valid_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      sample_cnt_nx = sample_cnt;
      err_cnt_nx    = err_cnt;
      pass_nx       = pass;
      mismatch_nx   = 1'b0;
      fail_a_nx     = fail_a;
      fail_b_nx     = fail_b;
      fail_out_nx   = fail_out;
      fail_valid_nx = fail_valid;

      case (state)
         S_IDLE, S_DONE: begin
            // start from either resting state begins a fresh run; the start-cycle sample is dropped
            if (start) begin
               state_nx      = S_RUN;
               sample_cnt_nx = '0;
               err_cnt_nx    = '0;
               pass_nx       = 1'b0;
               fail_a_nx     = '0;
               fail_b_nx     = '0;
               fail_out_nx   = 1'b0;
               fail_valid_nx = 1'b0;
            end
         end
         S_RUN: begin
            if (sample_hit) begin
               sample_cnt_nx = sample_cnt + CNT_WIDTH'(1);
            end
            if (miss) begin
               mismatch_nx = 1'b1;
               if (err_cnt != CNT_MAX) begin
                  err_cnt_nx = err_cnt + CNT_WIDTH'(1);
               end
               if (!fail_valid) begin
                  fail_a_nx     = a;
                  fail_b_nx     = b;
                  fail_out_nx   = dut_out;
                  fail_valid_nx = 1'b1;
               end
            end
            // pass is judged on the post-update counts so the final sample is included
            if ((sample_hit && (sample_cnt_nx == CNT_LAST)) || stop) begin
               state_nx = S_DONE;
               pass_nx  = (err_cnt_nx == '0) && (sample_cnt_nx != '0);
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   assign busy = (state == S_RUN);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_le_response_checker.sv
// Directed bench for le_response_checker: two instances (default sizing and a 2-bit counter,
// 3-vector variant) share stimulus and are checked every cycle against a run-level model.
module tb_le_response_checker;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic       valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       dut_out;

   logic       m_busy, m_done, m_pass, m_mism, m_fout, m_fv;
   logic [7:0] m_cnt, m_err;
   logic [3:0] m_fa, m_fb;
   logic       s_busy, s_done, s_pass, s_mism, s_fout, s_fv;
   logic [1:0] s_cnt, s_err;
   logic [3:0] s_fa, s_fb;

   le_response_checker #(.WIDTH(4), .CNT_WIDTH(8), .NUM_VECTORS(5)) u_main (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
      .a(a), .b(b), .dut_out(dut_out),
      .busy(m_busy), .done(m_done), .pass(m_pass), .mismatch(m_mism),
      .sample_cnt(m_cnt), .err_cnt(m_err), .fail_a(m_fa), .fail_b(m_fb),
      .fail_out(m_fout), .fail_valid(m_fv)
   );

   le_response_checker #(.WIDTH(4), .CNT_WIDTH(2), .NUM_VECTORS(3)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .valid(valid),
      .a(a), .b(b), .dut_out(dut_out),
      .busy(s_busy), .done(s_done), .pass(s_pass), .mismatch(s_mism),
      .sample_cnt(s_cnt), .err_cnt(s_err), .fail_a(s_fa), .fail_b(s_fb),
      .fail_out(s_fout), .fail_valid(s_fv)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;
   int mism_pulses = 0;

   // ---------------- run-level model (index 0 = main, 1 = small) ----------------
   int nv[2] = '{5, 3};
   int mx[2] = '{255, 3};
   int md_phase[2];   // 0 idle, 1 running, 2 finished
   int md_cnt[2], md_err[2], md_fa[2], md_fb[2];
   int md_pass[2], md_mism[2], md_fo[2], md_fv[2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         md_mism[i] = 0;
         if (!rst_n) begin
            md_phase[i] = 0; md_cnt[i] = 0; md_err[i] = 0; md_pass[i] = 0;
            md_fa[i] = 0; md_fb[i] = 0; md_fo[i] = 0; md_fv[i] = 0;
         end else if (md_phase[i] == 1) begin
            if (valid) begin
               md_cnt[i]++;
               if (int'(dut_out) != ((int'(a) <= int'(b)) ? 1 : 0)) begin
                  md_mism[i] = 1;
                  md_err[i] = (md_err[i] + 1 > mx[i]) ? mx[i] : md_err[i] + 1;
                  if (md_fv[i] == 0) begin
                     md_fa[i] = a; md_fb[i] = b; md_fo[i] = dut_out; md_fv[i] = 1;
                  end
               end
            end
            if (md_cnt[i] == nv[i] || stop) begin
               md_phase[i] = 2;
               md_pass[i] = (md_err[i] == 0 && md_cnt[i] != 0) ? 1 : 0;
            end
         end else if (start) begin
            md_phase[i] = 1; md_cnt[i] = 0; md_err[i] = 0; md_pass[i] = 0;
            md_fa[i] = 0; md_fb[i] = 0; md_fo[i] = 0; md_fv[i] = 0;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic chk_inst(input int i, input logic bz, dn, ps, mm, input int cnt, err,
                           input int fa, fb, input logic fo, fv);
      chk($sformatf("i%0d busy", i), bz, (md_phase[i] == 1) ? 1 : 0);
      chk($sformatf("i%0d done", i), dn, (md_phase[i] == 2) ? 1 : 0);
      chk($sformatf("i%0d pass", i), ps, md_pass[i]);
      chk($sformatf("i%0d mismatch", i), mm, md_mism[i]);
      chk($sformatf("i%0d sample_cnt", i), cnt, md_cnt[i]);
      chk($sformatf("i%0d err_cnt", i), err, md_err[i]);
      chk($sformatf("i%0d fail_a", i), fa, md_fa[i]);
      chk($sformatf("i%0d fail_b", i), fb, md_fb[i]);
      chk($sformatf("i%0d fail_out", i), fo, md_fo[i]);
      chk($sformatf("i%0d fail_valid", i), fv, md_fv[i]);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk_inst(0, m_busy, m_done, m_pass, m_mism, m_cnt, m_err, m_fa, m_fb, m_fout, m_fv);
         chk_inst(1, s_busy, s_done, s_pass, s_mism, s_cnt, s_err, s_fa, s_fb, s_fout, s_fv);
         if (m_mism) mism_pulses++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input logic st, sp, v, input int av, bv, input logic o);
      logic [31:0] av_l, bv_l;
      av_l = av; bv_l = bv;
      start = st; stop = sp; valid = v;
      a = av_l[3:0]; b = bv_l[3:0]; dut_out = o;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // bad=1 forces dut_out high; otherwise the comparator under test answers correctly
   task automatic vec(input int av, bv, input bit bad);
      cyc(1'b0, 1'b0, 1'b1, av, bv, bad ? 1'b1 : ((av <= bv) ? 1'b1 : 1'b0));
   endtask

   task automatic run_table(input bit bad);
      int va[5] = '{0, 2, 3, 4, 3};
      int vb[5] = '{0, 0, 1, 6, 2};
      for (int k = 0; k < 5; k++) vec(va[k], vb[k], bad);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; valid = 1'b0;
      a = '0; b = '0; dut_out = 1'b0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      idle(1);
      chk("reset busy", m_busy, 0);
      chk("reset sample_cnt", m_cnt, 0);
      rst_n = 1'b1;
      idle(1);

      // correct comparator over the reference table
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      run_table(1'b0);
      chk("t1 done", m_done, 1);
      chk("t1 sample_cnt", m_cnt, 5);
      chk("t1 err_cnt", m_err, 0);
      chk("t1 pass", m_pass, 1);
      chk("t1 fail_valid", m_fv, 0);
      chk("t1 small sample_cnt", s_cnt, 3);
      idle(2);

      // stuck-at-1 comparator: (2,0), (3,1), (3,2) must miss
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      mism_pulses = 0;
      run_table(1'b1);
      idle(1);
      chk("t2 err_cnt", m_err, 3);
      chk("t2 pass", m_pass, 0);
      chk("t2 fail_a", m_fa, 2);
      chk("t2 fail_b", m_fb, 0);
      chk("t2 fail_out", m_fout, 1);
      chk("t2 mismatch pulses", mism_pulses, 3);

      // equality and extreme operands, then stop
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 5, 5, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 15, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 15, 0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("bnd err_cnt", m_err, 1);
      chk("bnd fail_a", m_fa, 15);
      chk("bnd done", m_done, 1);

      // stop before any sample
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      chk("nosamp done", m_done, 1);
      chk("nosamp pass", m_pass, 0);
      chk("nosamp sample_cnt", m_cnt, 0);

      // stop coincident with a valid sample; later samples ignored
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      vec(1, 2, 1'b0);
      vec(9, 3, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 7, 7, 1'b1);
      chk("t3 sample_cnt", m_cnt, 3);
      chk("t3 done", m_done, 1);
      vec(4, 1, 1'b1);
      vec(0, 8, 1'b0);
      chk("t3 hold sample_cnt", m_cnt, 3);
      chk("t3 hold err_cnt", m_err, 0);

      // four misses: small instance ends at 3 without wrapping
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) vec(7, 1, 1'b1);
      chk("sat small err_cnt", s_err, 3);
      chk("sat small done", s_done, 1);
      chk("sat main err_cnt", m_err, 4);
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);

      // reset mid-run after two misses
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      vec(8, 2, 1'b1);
      vec(6, 5, 1'b1);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("rst err_cnt", m_err, 0);
      chk("rst fail_valid", m_fv, 0);
      vec(8, 2, 1'b1);
      vec(1, 1, 1'b0);
      chk("rst idle sample_cnt", m_cnt, 0);
      chk("rst idle busy", m_busy, 0);

      // back-to-back: finish a failing run, restart with valid on the start cycle
      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      vec(3, 0, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 2, 0, 1'b1);
      chk("b2b sample_cnt", m_cnt, 0);
      chk("b2b busy", m_busy, 1);
      chk("b2b fail_valid", m_fv, 0);
      run_table(1'b0);
      chk("b2b pass", m_pass, 1);
      chk("b2b err_cnt", m_err, 0);
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
